game_score_ctrl: RTL and testbench

//  Game-flow FSM for the VGA pong game. Sequences the 2-digit BCD score counter:

---
 rtl/game_score_ctrl_if.sv | 57 +++++
 rtl/game_score_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_game_score_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/game_score_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : game_score_ctrl_if
// Description : Signal bundle between the pong game-flow controller, the
//               pixel/collision logic, the BCD score counter and the text
//               overlay.
//               slave  modport : the game_score_ctrl side
//               master modport : the environment side (collision logic,
//                                score counter, overlay)
//               Signals:
//                 tick_60hz  1-cycle frame tick
//                 btn        debounced, synchronised start button level
//                 hit, miss  1-cycle collision pulses
//                 dig1, dig0 current BCD score (tens, units)
//                 d_inc      score increment strobe
//                 d_clr      score clear strobe
//                 gra_still  graphics frozen
//                 lives      balls remaining
//                 game_over  game-over screen select
//                 hs_dig1/0  high score (only with HIGH_SCORE_EN)
//               Optional feature macro: HIGH_SCORE_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface game_score_ctrl_if;
  logic       tick_60hz;
  logic       btn;
  logic       hit;
  logic       miss;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       d_inc;
  logic       d_clr;
  logic       gra_still;
  logic [2:0] lives;
  logic       game_over;
`ifdef HIGH_SCORE_EN
  logic [3:0] hs_dig1;
  logic [3:0] hs_dig0;
`endif

  modport slave (
    input  tick_60hz, btn, hit, miss, dig1, dig0,
`ifdef HIGH_SCORE_EN
    output hs_dig1, hs_dig0,
`endif
    output d_inc, d_clr, gra_still, lives, game_over
  );

  modport master (
    output tick_60hz, btn, hit, miss, dig1, dig0,
`ifdef HIGH_SCORE_EN
    input  hs_dig1, hs_dig0,
`endif
    input  d_inc, d_clr, gra_still, lives, game_over
  );
endinterface
`default_nettype wire

// File: rtl/game_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_score_ctrl
// Description : Game-flow FSM for the VGA pong game. Sequences the 2-digit
//               BCD score counter (d_inc / d_clr strobes, reads dig1/dig0),
//               tracks the remaining balls, freezes graphics between balls
//               and times the game-over screen in frame ticks.
// Ports       : clk    system clock
//               reset  asynchronous, active-low reset
//               bus    game_score_ctrl_if.slave (see interface header)
// Parameters  : LIVES        balls per game (1..7)
//               WAIT_FRAMES  frame ticks the game-over screen is held (1..255)
// Options     : HIGH_SCORE_EN - adds a high-score register pair
//               (bus.hs_dig1 / bus.hs_dig0) updated at the end of each game.
// Revision    : 1.0 - initial release
// ============================================================================
module game_score_ctrl #(
  parameter int LIVES       = 3,
  parameter int WAIT_FRAMES = 120
) (
  input  wire logic        clk,
  input  wire logic        reset,
  game_score_ctrl_if.slave bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [2:0] C_LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] C_WAIT_INIT  = 8'(WAIT_FRAMES);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [2:0] lives_q,     lives_d;
  logic [7:0] timer_q,     timer_d;
  logic       d_inc_q,     d_inc_d;
  logic       d_clr_q,     d_clr_d;
  logic       gra_still_q, gra_still_d;
  logic       game_over_q, game_over_d;
  logic       btn_q;

  logic       btn_rise;
  logic       score_sat;
  logic       enter_over;

  assign btn_rise  = bus.btn & ~btn_q;
  // 99 is the top of the two-digit counter; further hits must not wrap it.
  assign score_sat = (bus.dig1 == 4'd9) && (bus.dig0 == 4'd9);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_NEWGAME;
      lives_q     <= C_LIVES_INIT;
      timer_q     <= 8'd0;
      d_inc_q     <= 1'b0;
      d_clr_q     <= 1'b0;
      gra_still_q <= 1'b1;
      game_over_q <= 1'b0;
      btn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      d_inc_q     <= d_inc_d;
      d_clr_q     <= d_clr_d;
      gra_still_q <= gra_still_d;
      game_over_q <= game_over_d;
      btn_q       <= bus.btn;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    d_inc_d    = 1'b0;
    d_clr_d    = 1'b0;
    enter_over = 1'b0;

    case (state_q)
      ST_NEWGAME: begin
        if (btn_rise) begin
          state_d = ST_PLAY;
          d_clr_d = 1'b1;
          lives_d = C_LIVES_INIT;
        end
      end

      ST_PLAY: begin
        // Hit and miss are evaluated independently so a coincident pair
        // both scores and costs a life.
        if (bus.hit && !score_sat) begin
          d_inc_d = 1'b1;
        end
        if (bus.miss) begin
          if (lives_q <= 3'd1) begin
            lives_d    = 3'd0;
            state_d    = ST_OVER;
            timer_d    = C_WAIT_INIT;
            enter_over = 1'b1;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = ST_NEWBALL;
          end
        end
      end

      ST_NEWBALL: begin
        if (btn_rise) begin
          state_d = ST_PLAY;
        end
      end

      ST_OVER: begin
        if (bus.tick_60hz) begin
          // Reaching 1 (not 0) ends the hold so exactly WAIT_FRAMES ticks
          // are spent on the game-over screen.
          if (timer_q <= 8'd1) begin
            timer_d = 8'd0;
            state_d = ST_NEWGAME;
            lives_d = C_LIVES_INIT;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_NEWGAME;
        lives_d = C_LIVES_INIT;
        timer_d = 8'd0;
      end
    endcase

    // Frame/overlay flags follow the state being entered so that they
    // change on the same edge as the state itself.
    gra_still_d = (state_d != ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // --------------------------------------------------------------------------
  // Optional high score
  // --------------------------------------------------------------------------
`ifdef HIGH_SCORE_EN
  logic [3:0] hs_dig1_q, hs_dig1_d;
  logic [3:0] hs_dig0_q, hs_dig0_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_dig1_q <= 4'd0;
      hs_dig0_q <= 4'd0;
    end else begin
      hs_dig1_q <= hs_dig1_d;
      hs_dig0_q <= hs_dig0_d;
    end
  end

  // Packed BCD digits compare correctly as a plain 8-bit number
  // (tens in the upper nibble).
  always_comb begin
    hs_dig1_d = hs_dig1_q;
    hs_dig0_d = hs_dig0_q;
    if (enter_over && ({bus.dig1, bus.dig0} > {hs_dig1_q, hs_dig0_q})) begin
      hs_dig1_d = bus.dig1;
      hs_dig0_d = bus.dig0;
    end
  end

  assign bus.hs_dig1 = hs_dig1_q;
  assign bus.hs_dig0 = hs_dig0_q;
`else
  // enter_over has no consumer when the high score is absent.
  logic unused_enter_over;
  assign unused_enter_over = enter_over;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.d_inc     = d_inc_q;
  assign bus.d_clr     = d_clr_q;
  assign bus.gra_still = gra_still_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_score_ctrl
// Description : Self-checking bench for game_score_ctrl. Directed steps
//               drive one cycle at a time; the expected registered outputs
//               for each step are queued when the step is driven and
//               compared after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_score_ctrl;

  localparam int LIVES       = 3;
  localparam int WAIT_FRAMES = 120;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  game_score_ctrl_if bus ();

  game_score_ctrl #(
    .LIVES      (LIVES),
    .WAIT_FRAMES(WAIT_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d_inc;
    logic       d_clr;
    logic       gs;
    logic       go;
    logic [2:0] lives;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic exp_t mk(input logic di, input logic dc, input logic gs,
                              input logic go, input logic [2:0] l);
    exp_t e;
    e.d_inc = di;
    e.d_clr = dc;
    e.gs    = gs;
    e.go    = go;
    e.lives = l;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".d_inc"},     8'(bus.d_inc),     8'(e.d_inc));
    chk({tag, ".d_clr"},     8'(bus.d_clr),     8'(e.d_clr));
    chk({tag, ".gra_still"}, 8'(bus.gra_still), 8'(e.gs));
    chk({tag, ".game_over"}, 8'(bus.game_over), 8'(e.go));
    chk({tag, ".lives"},     8'(bus.lives),     8'(e.lives));
  endtask

  // One clock of stimulus; the expectation describes the outputs after
  // the edge that samples these inputs.
  task automatic cyc(input logic h, input logic m, input logic b, input logic t,
                     input exp_t e, input string tag);
    exp_t  got_e;
    string got_t;
    @(negedge clk);
    bus.hit       = h;
    bus.miss      = m;
    bus.btn       = b;
    bus.tick_60hz = t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    got_t = tag_q.pop_front();
    chk_all(got_t, got_e);
  endtask

  task automatic chk_hs(input string tag, input logic [3:0] t, input logic [3:0] u);
`ifdef HIGH_SCORE_EN
    chk({tag, ".hs"}, {bus.hs_dig1, bus.hs_dig0}, {t, u});
`endif
  endtask

  // Start a game, end it with the given score on the third miss.
  task automatic lose_game(input logic [3:0] d1, input logic [3:0] d0, input string tag);
    cyc(0, 0, 1, 0, mk(0, 1, 0, 0, 3), {tag, "_start"});
    bus.dig1 = d1;
    bus.dig0 = d0;
    cyc(0, 1, 0, 0, mk(0, 0, 1, 0, 2), {tag, "_miss1"});
    cyc(0, 0, 1, 0, mk(0, 0, 0, 0, 2), {tag, "_serve2"});
    cyc(0, 1, 0, 0, mk(0, 0, 1, 0, 1), {tag, "_miss2"});
    cyc(0, 0, 1, 0, mk(0, 0, 0, 0, 1), {tag, "_serve3"});
    cyc(0, 1, 0, 0, mk(0, 0, 1, 1, 0), {tag, "_miss3"});
  endtask

  // Game-over hold: btn and hit ignored, exit on the WAIT_FRAMES-th tick.
  task automatic over_wait(input string tag);
    cyc(0, 0, 0, 0, mk(0, 0, 1, 1, 0), {tag, "_over_idle"});
    cyc(0, 0, 1, 0, mk(0, 0, 1, 1, 0), {tag, "_over_btn"});
    cyc(1, 0, 0, 0, mk(0, 0, 1, 1, 0), {tag, "_over_hit"});
    for (int i = 1; i <= WAIT_FRAMES; i++) begin
      if (i < WAIT_FRAMES) begin
        cyc(0, 0, 0, 1, mk(0, 0, 1, 1, 0), {tag, "_tick"});
        cyc(0, 0, 0, 0, mk(0, 0, 1, 1, 0), {tag, "_gap"});
      end else begin
        cyc(0, 0, 0, 1, mk(0, 0, 1, 0, 3), {tag, "_tick_last"});
      end
    end
    cyc(0, 0, 0, 1, mk(0, 0, 1, 0, 3), {tag, "_newgame_tick"});
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    bus.hit = 0; bus.miss = 0; bus.btn = 0; bus.tick_60hz = 0;
    reset = 1'b0;
    #1;
    chk_all({tag, "_async"}, mk(0, 0, 1, 0, 3));
    @(posedge clk);
    #1;
    chk_all({tag, "_held"}, mk(0, 0, 1, 0, 3));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.hit = 0; bus.miss = 0; bus.btn = 0; bus.tick_60hz = 0;
    bus.dig1 = 4'd0; bus.dig0 = 4'd0;
    #2;
    reset_pulse("por");
    chk_hs("por", 4'd0, 4'd0);

    // NEWGAME: collision pulses and ticks ignored
    cyc(1, 1, 0, 1, mk(0, 0, 1, 0, 3), "newgame_ignore");
    // Start on button edge, held button gives no second event
    cyc(0, 0, 1, 0, mk(0, 1, 0, 0, 3), "start");
    cyc(0, 0, 1, 0, mk(0, 0, 0, 0, 3), "hold1");
    cyc(0, 0, 1, 0, mk(0, 0, 0, 0, 3), "hold2");

    // Five separated hits, then two back-to-back
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0, mk(1, 0, 0, 0, 3), "hit");
      cyc(0, 0, 1, 0, mk(0, 0, 0, 0, 3), "hit_gap");
    end
    cyc(1, 0, 1, 0, mk(1, 0, 0, 0, 3), "b2b_a");
    cyc(1, 0, 1, 0, mk(1, 0, 0, 0, 3), "b2b_b");
    cyc(0, 0, 1, 1, mk(0, 0, 0, 0, 3), "play_tick");

    // Saturated score suppresses the increment
    bus.dig1 = 4'd9; bus.dig0 = 4'd9;
    cyc(1, 0, 1, 0, mk(0, 0, 0, 0, 3), "sat_hit");
    bus.dig1 = 4'd9; bus.dig0 = 4'd8;
    cyc(1, 0, 1, 0, mk(1, 0, 0, 0, 3), "near_sat_hit");
    bus.dig1 = 4'd0; bus.dig0 = 4'd5;

    // Coincident hit and miss
    cyc(1, 1, 0, 0, mk(1, 0, 1, 0, 2), "hit_miss");
    cyc(1, 1, 0, 0, mk(0, 0, 1, 0, 2), "newball_ignore");
    cyc(0, 0, 1, 0, mk(0, 0, 0, 0, 2), "serve");

    // Reset mid-PLAY with lives=2
    reset_pulse("midplay");
    cyc(0, 0, 0, 0, mk(0, 0, 1, 0, 3), "after_reset");

    // Full games and high-score tracking
    lose_game(4'd4, 4'd2, "g1");
    chk_hs("g1", 4'd4, 4'd2);
    over_wait("g1");
    lose_game(4'd1, 4'd7, "g2");
    chk_hs("g2", 4'd4, 4'd2);
    over_wait("g2");
    lose_game(4'd5, 4'd7, "g3");
    chk_hs("g3", 4'd5, 4'd7);
    over_wait("g3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
